// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (16-bit word count, little-endian
// instruction words, XOR checksum), writes the words sequentially into
// instruction memory from address 0, and holds the core in reset until the
// whole image has been written and its checksum matches.
`timescale 1ns / 1ps

module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           n_q, n_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  // Only the three low lanes need storage; the 4th byte goes straight into the write data.
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            chk_q, chk_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  xfer;
  logic [15:0]           n_full;

  // Handshake readiness is a pure function of state.
  always_comb begin
    in_ready = (state_q == StHdr0) || (state_q == StHdr1) ||
               (state_q == StData) || (state_q == StChk);
  end

  // Next-state logic: header decode, word assembly, checksum and write strobe.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    n_d        = n_q;
    cnt_lo_d   = cnt_lo_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    xfer       = in_valid && in_ready;
    n_full     = {in_data, cnt_lo_q};

    unique case (state_q)
      StHdr0: begin
        if (xfer) begin
          cnt_lo_d = in_data;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          n_d = n_full;
          if (32'(n_full) > DEPTH) begin
            state_d = StErr;
          end else if (n_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            2'd3: begin
              we_d       = 1'b1;
              addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
              wdata_d    = {in_data, asm_q};
              word_cnt_d = word_cnt_q + 16'd1;
              if (word_cnt_q == n_q - 16'd1) begin
                state_d = StChk;
              end
            end
          endcase
        end
      end
      StChk: begin
        if (xfer) begin
          state_d = (in_data == chk_q) ? StDone : StErr;
        end
      end
      StDone: state_d = StDone;
      StErr:  state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // State register with synchronous reset; a partial word is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHdr0;
      byte_idx_q <= 2'd0;
      word_cnt_q <= 16'd0;
      n_q        <= 16'd0;
      cnt_lo_q   <= 8'd0;
      asm_q      <= 24'd0;
      chk_q      <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      cnt_lo_q   <= cnt_lo_d;
      asm_q      <= asm_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Status outputs; the core is released only once the image is verified.
  always_comb begin
    imem_we    = we_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    done       = (state_q == StDone);
    error      = (state_q == StErr);
    cpu_hold   = (state_q != StDone);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: one task per scenario, inline checks.
`timescale 1ns / 1ps

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  prog_loader #(
    .ADDR_WIDTH(5),
    .DEPTH     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One idle cycle, then the byte.
  task automatic send_byte_gap(input logic [7:0] b);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    @(posedge clk);
    #1;
    send_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tests++;
    if (imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_imem got we=%b addr=%0d data=%h exp 0/0/0", imem_we, imem_addr,
               imem_wdata);
    end
    tests++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL reset_status got hold=%b done=%b err=%b exp 1/0/0", cpu_hold, done, error);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'h00500093) begin
      fails++;
      $display("FAIL basic_write0 got we=%b addr=%0d data=%h exp 1/0/00500093", imem_we,
               imem_addr, imem_wdata);
    end
    send_byte(8'h13);
    tests++;
    if (imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'h00500093) begin
      fails++;
      $display("FAIL basic_hold got we=%b addr=%0d data=%h exp 0/0/00500093", imem_we,
               imem_addr, imem_wdata);
    end
    tests++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL basic_loading got hold=%b done=%b exp 1/0", cpu_hold, done);
    end
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 5'd1 || imem_wdata !== 32'h00100113) begin
      fails++;
      $display("FAIL basic_write1 got we=%b addr=%0d data=%h exp 1/1/00100113", imem_we,
               imem_addr, imem_wdata);
    end
    send_byte(8'hC1);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_done got done=%b hold=%b err=%b rdy=%b exp 1/0/0/0", done, cpu_hold,
               error, in_ready);
    end
    send_byte(8'h77);
    idle(2);
    tests++;
    if (wr_addr.size() != 2 || done !== 1'b1) begin
      fails++;
      $display("FAIL basic_count got writes=%0d done=%b exp 2/1", wr_addr.size(), done);
    end else begin
      tests++;
      if (wr_cyc[1] - wr_cyc[0] != 4) begin
        fails++; $display("FAIL basic_spacing got=%0d exp=4", wr_cyc[1] - wr_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    send_byte_gap(8'h02); send_byte_gap(8'h00);
    send_byte_gap(8'h93); send_byte_gap(8'h00); send_byte_gap(8'h50); send_byte_gap(8'h00);
    send_byte_gap(8'h13); send_byte_gap(8'h01); send_byte_gap(8'h10); send_byte_gap(8'h00);
    send_byte_gap(8'hC1);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL stall_done got done=%b hold=%b exp 1/0", done, cpu_hold);
    end
    idle(2);
    tests++;
    if (wr_addr.size() != 2) begin
      fails++; $display("FAIL stall_count got=%0d exp=2", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00500093 ||
          wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h00100113) begin
        fails++;
        $display("FAIL stall_writes got %0d:%h %0d:%h exp 0:00500093 1:00100113", wr_addr[0],
                 wr_data[0], wr_addr[1], wr_data[1]);
      end
      tests++;
      if (wr_cyc[1] - wr_cyc[0] != 8) begin
        fails++; $display("FAIL stall_spacing got=%0d exp=8", wr_cyc[1] - wr_cyc[0]);
      end
    end
  endtask

  task automatic test_bad_chk();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h3E);
    tests++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL badchk_status got err=%b done=%b hold=%b rdy=%b exp 1/0/1/0", error, done,
               cpu_hold, in_ready);
    end
    // A now-correct checksum byte must be ignored in the terminal state.
    send_byte(8'hC1);
    idle(2);
    tests++;
    if (error !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL badchk_sticky got err=%b done=%b exp 1/0", error, done);
    end
    tests++;
    if (wr_addr.size() != 2) begin
      fails++; $display("FAIL badchk_writes got=%0d exp=2", wr_addr.size());
    end
  endtask

  task automatic test_too_big();
    do_reset();
    send_byte(8'h21);
    tests++;
    if (error !== 1'b0) begin
      fails++; $display("FAIL big_early got err=%b exp=0", error);
    end
    send_byte(8'h00);
    tests++;
    if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL big_err got err=%b done=%b rdy=%b hold=%b exp 1/0/0/1", error, done,
               in_ready, cpu_hold);
    end
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    idle(2);
    tests++;
    if (wr_addr.size() != 0) begin
      fails++; $display("FAIL big_writes got=%0d exp=0", wr_addr.size());
    end
  endtask

  task automatic test_zero();
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    tests++;
    if (in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL zero_chkwait got rdy=%b done=%b err=%b exp 1/0/0", in_ready, done, error);
    end
    send_byte(8'h00);
    idle(2);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_done got done=%b hold=%b writes=%0d exp 1/0/0", done, cpu_hold,
               wr_addr.size());
    end
  endtask

  task automatic test_full();
    logic [31:0] w;
    logic [7:0]  chk;
    int          bad;
    chk = 8'h00;
    do_reset();
    send_byte(8'h20); send_byte(8'h00);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        chk = chk ^ w[8*b +: 8];
      end
    end
    tests++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL full_chkwait got rdy=%b done=%b exp 1/0", in_ready, done);
    end
    send_byte(chk);
    tests++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL full_done got done=%b err=%b hold=%b exp 1/0/0", done, error, cpu_hold);
    end
    idle(2);
    tests++;
    if (wr_addr.size() != 32) begin
      fails++; $display("FAIL full_count got=%0d exp=32", wr_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        w = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
        if (wr_addr[i] !== 5'(i) || wr_data[i] !== w) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL full_contents got bad_words=%0d exp=0", bad);
      end
      tests++;
      if (wr_addr[31] !== 5'd31) begin
        fails++; $display("FAIL full_last_addr got=%0d exp=31", wr_addr[31]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00);
    do_reset();
    tests++;
    if (imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0 || in_ready !== 1'b1 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state got we=%b addr=%0d data=%h rdy=%b hold=%b done=%b err=%b",
               imem_we, imem_addr, imem_wdata, in_ready, cpu_hold, done, error);
    end
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h02);
    idle(2);
    tests++;
    if (wr_addr.size() != 1) begin
      fails++; $display("FAIL midrst_count got=%0d exp=1", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00100113) begin
        fails++;
        $display("FAIL midrst_write got %0d:%h exp 0:00100113", wr_addr[0], wr_data[0]);
      end
    end
    tests++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL midrst_done got done=%b err=%b hold=%b exp 1/0/0", done, error, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_chk();
    test_too_big();
    test_zero();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
